block_acc_writer: RTL and testbench
===================================

Name: block_acc_writer

Overview:
- Downstream stage of the blocked matrix-multiply data mover.
- Consumes the pair-wise 16-bit partial products from the matrix cores, two C elements per beat, and accumulates one BLOCK_SIZE x BLOCK_SIZE C block over MATRIX_SIZE/BLOCK_SIZE k-passes in a local buffer.
- Drains each finished block into the result BRAM (BRAM1) at its blocked address, then pulses a go signal so the upstream reader starts the next block.

Parameters:
- IN_DATA_WIDTH, 8: operand width; accumulator width ACC_WIDTH = 2*IN_DATA_WIDTH.
- MATRIX_SIZE, 128: square matrix dimension.
- BLOCK_SIZE, 16: block dimension; power of two, divides MATRIX_SIZE.
- DWIDTH, 32: BRAM word width; must equal 2*ACC_WIDTH.
- AWIDTH, 13: BRAM1 address width; holds MATRIX_SIZE*MATRIX_SIZE/2 words.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse that starts a full C-matrix job; ignored unless idle.
- i_valid  in  1  partial-product beat valid.
- o_ready  out  1  beat accepted when i_valid && o_ready.
- i_result0  in  ACC_WIDTH  partial product for element 2n of the current block row-major pair n.
- i_result1  in  ACC_WIDTH  partial product for element 2n+1.
- o_block_done  out  1  one-cycle pulse after a block drain completes (upstream go signal).
- o_idle  out  1  state == S_IDLE.
- o_done  out  1  one-cycle pulse when the last block is written.
- addr_b1  out  AWIDTH  BRAM1 address.
- ce_b1  out  1  BRAM1 chip enable.
- we_b1  out  1  BRAM1 write enable.
- d_b1  out  DWIDTH  BRAM1 write data.

Behaviour:
- Reset values: all outputs 0 except o_idle = 1. State is S_IDLE; all counters are 0.
- Constants:
  - PAIRS = BLOCK_SIZE*BLOCK_SIZE/2 (128).
  - KPASS = MATRIX_SIZE/BLOCK_SIZE (8).
  - NBLK = KPASS*KPASS (64).
- Buffer: PAIRS entries of {acc0, acc1}, each ACC_WIDTH wide. Read is combinational.
- Counters:
  - pair_idx: 0..PAIRS-1, wraps.
  - k_cnt: 0..KPASS-1.
  - blk_cnt: 0..NBLK-1.
- FSM:
  - S_IDLE: on i_start, go to S_CLEAR with pair_idx = 0 and blk_cnt = 0.
  - S_CLEAR: zero entry pair_idx each cycle, taking PAIRS cycles. After the last entry, go to S_ACC.
  - S_ACC: o_ready = 1. Each accepted beat does entry[pair_idx] += {i_result0, i_result1}, per half, modulo 2^ACC_WIDTH; pair_idx then increments. On wrap, k_cnt increments. If the wrap completes pass KPASS-1, k_cnt goes to 0 and the FSM enters S_DRAIN.
  - S_DRAIN: one word per cycle, PAIRS cycles.
    - Registered outputs: ce_b1 = we_b1 = 1, addr_b1 = blk_cnt*PAIRS + pair_idx, d_b1 = {acc0, acc1} with acc0 in [DWIDTH-1:ACC_WIDTH].
    - The same cycle writes entry[pair_idx] = 0, so no separate clear is needed between blocks.
    - The write is visible on the BRAM port one cycle after the index is presented.
  - Drain completion, on the cycle after the last word is issued: o_block_done pulses and ce/we drop.
    - If blk_cnt == NBLK-1, go to S_DONE.
    - Otherwise blk_cnt increments and the FSM returns to S_ACC.
  - S_DONE: o_done pulses for one cycle, then S_IDLE.
- o_ready is 0 in every state except S_ACC. i_valid outside S_ACC is ignored; upstream holds data until ready.
- i_start while not idle is ignored.
- Block address ordering: blk_cnt = i*KPASS + j, matching the upstream (i, j, k) loop order with k innermost.
- Reset mid-operation: immediate return to S_IDLE, outputs to reset values. Buffer contents are don't-care because S_CLEAR runs on the next start.
- Throughput: one beat per cycle in S_ACC; block latency = KPASS*PAIRS accepted beats + PAIRS drain cycles + 1.

Decomposition:
- Shared package:
  - State encoding S_IDLE, S_CLEAR, S_ACC, S_DRAIN, S_DONE.
  - Derived constants PAIRS, KPASS, NBLK, ACC_WIDTH.
- One natural sub-module: acc_pair_buffer. It is the PAIRS x 2*ACC_WIDTH register array with ports for clear, add-pair and read-then-zero, indexed by pair_idx.
- The FSM, counters and BRAM1 port register live in the top module.

Test Plan:
- Reset, no stimulus -> o_idle = 1, o_ready = 0, ce_b1 = we_b1 = 0, addr_b1 = 0 for 200 cycles.
- i_start, then 128 clear cycles, then 8 passes of 128 beats with i_result0 = 1, i_result1 = 2 -> 128 writes, addr_b1 0..127, every d_b1 = 0x00080010; o_block_done pulses once, one cycle after the last write.
- Second block: 8 passes with i_result0 = 0x2000, i_result1 = 0xFFFF -> addresses 128..255, d_b1 = 0x0000FFF8 (wrap-around), proving the buffer was zeroed by the first drain.
- Random i_valid gaps (about 50% duty) with incrementing data per pair -> sums are correct per pair; no beat is accepted while o_ready = 0; i_start pulsed mid-job has no effect.
- Full job of 64 blocks -> 8192 writes, addr_b1 0..8191 contiguous, o_done pulses once after the last write, then o_idle = 1.
- reset_n asserted mid-S_ACC, then a new i_start with all inputs 3 -> outputs zero immediately; the next block drains d_b1 = 0x00180018 everywhere.

Source files
------------

// File: rtl/block_acc_writer_pkg.sv
// block_acc_writer_pkg: shared FSM encoding, default sizing and sizing helpers
package block_acc_writer_pkg;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACC, S_DRAIN, S_DONE} state_t;

    localparam int DEF_IN_DATA_WIDTH = 8;
    localparam int DEF_MATRIX_SIZE   = 128;
    localparam int DEF_BLOCK_SIZE    = 16;

    function automatic int acc_width(input int in_w);
        return 2 * in_w;
    endfunction

    function automatic int pairs(input int bs);
        return bs * bs / 2;
    endfunction

    function automatic int kpass(input int ms, input int bs);
        return ms / bs;
    endfunction

    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_pair_buffer.sv
// acc_pair_buffer: PAIRS x {acc0, acc1} accumulator array with clear, add-pair
// and combinational read; clearing the read entry doubles as read-then-zero.
module acc_pair_buffer
    import block_acc_writer_pkg::*;
#(
    parameter int ACC_WIDTH = 16,
    parameter int PAIRS     = 128
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        add,
    input  logic [idx_w(PAIRS)-1:0]     idx,
    input  logic [ACC_WIDTH-1:0]        add0,
    input  logic [ACC_WIDTH-1:0]        add1,
    output logic [2*ACC_WIDTH-1:0]      rd
);

    // no reset: every job starts with a full clear pass
    logic [2*ACC_WIDTH-1:0] mem [PAIRS];

    assign rd = mem[idx];

    always_ff @(posedge clk) begin
        if (clr)
            mem[idx] <= '0;
        else if (add)
            mem[idx] <= {rd[2*ACC_WIDTH-1:ACC_WIDTH] + add0, rd[ACC_WIDTH-1:0] + add1};
    end

endmodule

// File: rtl/block_acc_writer.sv
// block_acc_writer: accumulates one C block over all k-passes, drains it to
// BRAM1 at its blocked address and pulses block_done to restart the reader.
module block_acc_writer
    import block_acc_writer_pkg::*;
#(
    parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
    parameter int MATRIX_SIZE   = DEF_MATRIX_SIZE,
    parameter int BLOCK_SIZE    = DEF_BLOCK_SIZE,
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 13
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_start,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [2*IN_DATA_WIDTH-1:0] i_result0,
    input  logic [2*IN_DATA_WIDTH-1:0] i_result1,
    output logic                       o_block_done,
    output logic                       o_idle,
    output logic                       o_done,
    output logic [AWIDTH-1:0]          addr_b1,
    output logic                       ce_b1,
    output logic                       we_b1,
    output logic [DWIDTH-1:0]          d_b1
);

    localparam int ACC_WIDTH = acc_width(IN_DATA_WIDTH);
    localparam int PAIRS     = pairs(BLOCK_SIZE);
    localparam int KPASS     = kpass(MATRIX_SIZE, BLOCK_SIZE);
    localparam int NBLK      = KPASS * KPASS;
    localparam int PW        = idx_w(PAIRS);
    localparam int KW        = idx_w(KPASS);
    localparam int BW        = idx_w(NBLK);
    localparam logic [PW-1:0] P_LAST = PW'(PAIRS - 1);
    localparam logic [KW-1:0] K_LAST = KW'(KPASS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(NBLK - 1);

    state_t                 state;
    logic [PW-1:0]          pair_idx;
    logic [KW-1:0]          k_cnt;
    logic [BW-1:0]          blk_cnt;
    logic [PW-1:0]          pair_nxt;
    logic [2*ACC_WIDTH-1:0] rd;
    logic                   drain_end;
    logic                   buf_clr;
    logic                   buf_add;

    // pair_idx wraps to 0 after the last word, and ce_b1 is still high only
    // on the cycle right after that word was issued
    assign drain_end = state == S_DRAIN && ce_b1 && pair_idx == '0;
    assign buf_clr   = state == S_CLEAR || (state == S_DRAIN && !drain_end);
    assign buf_add   = state == S_ACC && i_valid;
    assign pair_nxt  = pair_idx == P_LAST ? '0 : pair_idx + 1'b1;
    assign o_ready   = state == S_ACC;
    assign o_idle    = state == S_IDLE;

    acc_pair_buffer #(
        .ACC_WIDTH(ACC_WIDTH),
        .PAIRS    (PAIRS)
    ) u_buf (
        .clk (clk),
        .clr (buf_clr),
        .add (buf_add),
        .idx (pair_idx),
        .add0(i_result0),
        .add1(i_result1),
        .rd  (rd)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            pair_idx     <= '0;
            k_cnt        <= '0;
            blk_cnt      <= '0;
            o_block_done <= 1'b0;
            o_done       <= 1'b0;
            addr_b1      <= '0;
            ce_b1        <= 1'b0;
            we_b1        <= 1'b0;
            d_b1         <= '0;
        end else begin
            o_block_done <= 1'b0;
            o_done       <= 1'b0;
            case (state)
                S_IDLE: if (i_start) begin
                    state    <= S_CLEAR;
                    pair_idx <= '0;
                    k_cnt    <= '0;
                    blk_cnt  <= '0;
                end
                S_CLEAR: begin
                    pair_idx <= pair_nxt;
                    if (pair_idx == P_LAST) state <= S_ACC;
                end
                S_ACC: if (i_valid) begin
                    pair_idx <= pair_nxt;
                    if (pair_idx == P_LAST) begin
                        k_cnt <= k_cnt == K_LAST ? '0 : k_cnt + 1'b1;
                        if (k_cnt == K_LAST) state <= S_DRAIN;
                    end
                end
                S_DRAIN: if (drain_end) begin
                    ce_b1        <= 1'b0;
                    we_b1        <= 1'b0;
                    o_block_done <= 1'b1;
                    if (blk_cnt == B_LAST) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end else begin
                        blk_cnt <= blk_cnt + 1'b1;
                        state   <= S_ACC;
                    end
                end else begin
                    // PAIRS is a power of two, so blk_cnt*PAIRS + pair_idx is a concatenation
                    ce_b1    <= 1'b1;
                    we_b1    <= 1'b1;
                    addr_b1  <= AWIDTH'({blk_cnt, pair_idx});
                    d_b1     <= DWIDTH'(rd);
                    pair_idx <= pair_nxt;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_acc_writer.sv
// tb_block_acc_writer: table-driven block vectors over a full job on a reduced
// 64x64 matrix with 8x8 blocks (KPASS stays 8), plus reset/corner sequences.
module tb_block_acc_writer;

    localparam int MS    = 64;
    localparam int BS    = 8;
    localparam int PAIRS = BS * BS / 2;
    localparam int KPASS = MS / BS;
    localparam int NBLK  = KPASS * KPASS;
    localparam int AW    = 11;
    localparam int NV    = 7;

    typedef struct {
        logic [15:0] r0;
        logic [15:0] r1;
        logic [15:0] step;
        bit          gappy;
        logic [31:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [15:0]   i_result0 = '0;
    logic [15:0]   i_result1 = '0;
    logic          o_block_done;
    logic          o_idle;
    logic          o_done;
    logic [AW-1:0] addr_b1;
    logic          ce_b1;
    logic          we_b1;
    logic [31:0]   d_b1;

    vec_t vec [NV];
    int   tests = 0;
    int   fails = 0;
    int   wr_cnt = 0;
    int   bdone_cnt = 0;
    int   done_cnt = 0;
    int   job_off = 0;
    int   bd_base = 0;
    bit   prev_ce = 1'b0;
    int   mb, mp;
    vec_t mv;
    logic [15:0] minc;

    block_acc_writer #(
        .IN_DATA_WIDTH(8),
        .MATRIX_SIZE  (MS),
        .BLOCK_SIZE   (BS),
        .DWIDTH       (32),
        .AWIDTH       (AW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_start     (i_start),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_result0   (i_result0),
        .i_result1   (i_result1),
        .o_block_done(o_block_done),
        .o_idle      (o_idle),
        .o_done      (o_done),
        .addr_b1     (addr_b1),
        .ce_b1       (ce_b1),
        .we_b1       (we_b1),
        .d_b1        (d_b1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic abort(input string what);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT event", what);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // every drain word is checked against the block's vector; block index comes from the write count
    always @(negedge clk) begin
        if (o_idle) wr_cnt = 0;
        if (ce_b1) begin
            mb = wr_cnt / PAIRS;
            mp = wr_cnt % PAIRS;
            mv = vec[(mb + job_off) % NV];
            minc = 16'(KPASS * int'(mv.step) * mp);
            chk("we_b1", {31'd0, we_b1}, 32'd1);
            chk("addr_b1", {21'd0, addr_b1}, wr_cnt);
            chk("d_b1", d_b1, {mv.exp[31:16] + minc, mv.exp[15:0] + minc});
            wr_cnt++;
        end
        if (o_block_done) begin
            chk("bdone_after_last_write", {31'd0, prev_ce}, 32'd1);
            chk("bdone_ce_dropped", {31'd0, ce_b1}, 32'd0);
            chk("bdone_block_aligned", wr_cnt % PAIRS, 0);
            bdone_cnt++;
        end
        if (o_done) begin
            chk("done_total_writes", wr_cnt, PAIRS * NBLK);
            done_cnt++;
        end
        prev_ce = ce_b1;
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input bit gappy);
        int n;
        if (gappy) while ($urandom_range(0, 1) == 0) @(negedge clk);
        i_valid = 1'b1;
        i_result0 = a;
        i_result1 = b;
        n = 0;
        while (!o_ready) begin
            @(negedge clk);
            n++;
            if (n > 4 * PAIRS) abort("ready_wait");
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic start_job();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("clear_not_idle", {31'd0, o_idle}, 32'd0);
        repeat (PAIRS - 1) @(negedge clk);
        chk("clear_last_not_ready", {31'd0, o_ready}, 32'd0);
        @(negedge clk);
        chk("acc_ready", {31'd0, o_ready}, 32'd1);
    endtask

    task automatic feed_block(input int b);
        vec_t v;
        v = vec[(b + job_off) % NV];
        for (int k = 0; k < KPASS; k++) begin
            for (int p = 0; p < PAIRS; p++) begin
                if (b == 2 && k == 3 && p == 5) i_start = 1'b1;
                send(v.r0 + v.step * 16'(p), v.r1 + v.step * 16'(p), v.gappy);
                if (k == 0 && p == 0) chk("bdone_count_at_block", bdone_cnt, bd_base + b);
                if (b == 2 && k == 3 && p == 5) chk("mid_start_ignored", {31'd0, o_idle}, 32'd0);
            end
        end
    endtask

    task automatic wait_bdone(input int target);
        int n;
        n = 0;
        while (bdone_cnt < target) begin
            @(negedge clk);
            n++;
            if (n > 4 * PAIRS) abort("block_done_wait");
        end
    endtask

    initial begin
        #1_000_000;
        abort("global_watchdog");
    end

    initial begin
        int n;
        vec[0] = '{16'h0001, 16'h0002, 16'h0000, 1'b0, 32'h0008_0010};
        vec[1] = '{16'h2000, 16'hFFFF, 16'h0000, 1'b0, 32'h0000_FFF8};
        vec[2] = '{16'h0010, 16'h0100, 16'h0001, 1'b1, 32'h0080_0800};
        vec[3] = '{16'h7FFF, 16'h0001, 16'h0000, 1'b1, 32'hFFF8_0008};
        vec[4] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 32'h0000_0000};
        vec[5] = '{16'h1234, 16'h0F0F, 16'h0000, 1'b0, 32'h91A0_7878};
        vec[6] = '{16'h0003, 16'h0003, 16'h0000, 1'b0, 32'h0018_0018};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            chk("reset_quiet", {24'd0, o_idle, o_ready, ce_b1, we_b1, o_block_done, o_done,
                addr_b1 != '0, d_b1 != '0}, 32'h80);
        end

        job_off = 0;
        bd_base = bdone_cnt;
        start_job();
        for (int b = 0; b < NBLK; b++) feed_block(b);
        n = 0;
        while (done_cnt == 0) begin
            @(negedge clk);
            n++;
            if (n > 4 * PAIRS) abort("done_wait");
        end
        chk("job_block_dones", bdone_cnt - bd_base, NBLK);
        @(negedge clk);
        chk("job_idle_after_done", {30'd0, o_idle, o_ready}, 32'd2);
        chk("done_single_pulse", {31'd0, o_done}, 32'd0);
        chk("done_count", done_cnt, 1);

        start_job();
        repeat (100) send(16'd5, 16'd7, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("async_reset_flags", {26'd0, o_idle, o_ready, ce_b1, we_b1, o_block_done, o_done}, 32'h20);
        chk("async_reset_addr", {21'd0, addr_b1}, 32'd0);
        chk("async_reset_data", d_b1, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        job_off = 6;
        bd_base = bdone_cnt;
        i_result0 = 16'd3;
        i_result1 = 16'd3;
        start_job();
        feed_block(0);
        wait_bdone(bd_base + 1);
        chk("post_reset_block_writes", wr_cnt, PAIRS);
        @(negedge clk);
        chk("post_reset_next_block_acc", {30'd0, o_idle, o_ready}, 32'd1);
        chk("post_reset_no_done", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
